// File: rtl/tracker_edit_controller.sv
// Pattern-grid cursor and read-modify-write cell editor driven by held-key command codes.
// Each key class gets its own typematic repeat engine; edits run a fixed four-state RAM sequence.

module tracker_repeat #(
    parameter int          W      = 3,
    parameter logic [23:0] DELAY  = 24'd12_500_000,
    parameter logic [23:0] PERIOD = 24'd2_500_000
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic [W-1:0] code_in,
    output logic         fire,
    output logic [W-1:0] code
);
    logic [W-1:0] prev;
    logic [23:0]  count;

    always_ff @(posedge clk) begin
        if (Reset) begin
            prev  <= '0;
            count <= '0;
            fire  <= 1'b0;
            code  <= '0;
        end else begin
            prev <= code_in;
            if (code_in == '0) begin
                count <= '0;
                fire  <= 1'b0;
            end else if (code_in != prev) begin
                // a change between two nonzero codes restarts the typematic delay
                fire  <= 1'b1;
                count <= DELAY - 24'd1;
                code  <= code_in;
            end else if (count == 24'd0) begin
                fire  <= 1'b1;
                count <= PERIOD - 24'd1;
            end else begin
                fire  <= 1'b0;
                count <= count - 24'd1;
            end
        end
    end
endmodule

module tracker_edit_controller #(
    parameter int          ROW_W         = 6,
    parameter int          COL_W         = 2,
    parameter int          DATA_W        = 8,
    parameter logic [23:0] REPEAT_DELAY  = 24'd12_500_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd2_500_000
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic [2:0]             user_cursor,
    input  logic [1:0]             user_edit,
    output logic [ROW_W-1:0]       cursor_row,
    output logic [COL_W-1:0]       cursor_col,
    output logic [ROW_W+COL_W-1:0] mem_addr,
    output logic                   mem_rd_en,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   mem_wr_en,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   busy,
    output logic                   edit_done
);
    typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;

    state_t      state, state_next;
    logic [2:0]  cursor_code_in;
    logic        cursor_fire, edit_fire;
    logic [2:0]  cursor_code;
    logic [1:0]  edit_code;
    logic [1:0]  op;

    assign cursor_code_in = (user_cursor > 3'd4) ? 3'd0 : user_cursor;

    tracker_repeat #(.W(3), .DELAY(REPEAT_DELAY), .PERIOD(REPEAT_PERIOD)) u_cursor_rep (
        .clk(clk), .Reset(Reset), .code_in(cursor_code_in), .fire(cursor_fire), .code(cursor_code)
    );

    tracker_repeat #(.W(2), .DELAY(REPEAT_DELAY), .PERIOD(REPEAT_PERIOD)) u_edit_rep (
        .clk(clk), .Reset(Reset), .code_in(user_edit), .fire(edit_fire), .code(edit_code)
    );

    always_ff @(posedge clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (edit_fire) state_next = RD;
            RD:      state_next = WAIT;
            WAIT:    state_next = WR;
            WR:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = (state == RD);
        mem_wr_en = (state == WR);
        edit_done = (state == WR);
        busy      = (state != IDLE);
    end

    // Cursor moves only in IDLE, so mem_addr and the cursor agree for the whole edit.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cursor_row <= '0;
            cursor_col <= '0;
            mem_addr   <= '0;
            op         <= 2'b00;
            mem_wdata  <= '0;
        end else begin
            if (state == IDLE) begin
                if (edit_fire) begin
                    mem_addr <= {cursor_row, cursor_col};
                    op       <= edit_code;
                end else if (cursor_fire) begin
                    case (cursor_code)
                        3'd1:    cursor_col <= cursor_col - COL_W'(1);
                        3'd2:    cursor_col <= cursor_col + COL_W'(1);
                        3'd3:    cursor_row <= cursor_row - ROW_W'(1);
                        3'd4:    cursor_row <= cursor_row + ROW_W'(1);
                        default: ;
                    endcase
                end
            end
            if (state == WAIT) begin
                case (op)
                    2'b01:   mem_wdata <= mem_rdata + DATA_W'(1);
                    2'b10:   mem_wdata <= mem_rdata - DATA_W'(1);
                    default: mem_wdata <= '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tracker_edit_controller.sv
// Randomized bench for tracker_edit_controller: a press-age reference model predicts cursor
// motion and RAM writes; a negedge monitor compares DUT outputs and pops expected writes.

module tb_tracker_edit_controller;
    localparam int D = 10;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       Reset;
    logic [2:0] user_cursor;
    logic [1:0] user_edit;
    logic [5:0] cursor_row;
    logic [1:0] cursor_col;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       edit_done;

    tracker_edit_controller #(
        .ROW_W(6), .COL_W(2), .DATA_W(8),
        .REPEAT_DELAY(24'd10), .REPEAT_PERIOD(24'd4)
    ) dut (
        .clk(clk), .Reset(Reset), .user_cursor(user_cursor), .user_edit(user_edit),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .busy(busy), .edit_done(edit_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    bit run = 0;

    logic [7:0]  ram [256];
    logic [7:0]  ref_mem [256];
    logic [15:0] exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures < 40) $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // environment RAM: one-cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
        if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    end

    // reference model: fires derived from cycles since press, edits occupy three cycles
    int         m_row, m_col, m_busy, m_addr, m_op;
    int         cprev, eprev, cage, eage, m_cc, m_ec;
    bit         m_cf, m_ef;

    always @(posedge clk) begin
        int c, e, wd;
        if (Reset) begin
            m_row = 0; m_col = 0; m_busy = 0; m_addr = 0; m_op = 0;
            cprev = 0; eprev = 0; cage = 0; eage = 0; m_cf = 0; m_ef = 0;
            m_cc = 0; m_ec = 0;
            exp_q.delete();
        end else begin
            if (m_busy > 0) begin
                if (m_busy == 2) begin
                    if (m_op == 1)      wd = (ref_mem[m_addr] + 1) % 256;
                    else if (m_op == 2) wd = (ref_mem[m_addr] + 255) % 256;
                    else                wd = 0;
                    ref_mem[m_addr] = wd[7:0];
                    exp_q.push_back({m_addr[7:0], wd[7:0]});
                end
                m_busy--;
            end else if (m_ef) begin
                m_addr = m_row * 4 + m_col;
                m_op = m_ec;
                m_busy = 3;
            end else if (m_cf) begin
                case (m_cc)
                    1: m_col = (m_col + 3) % 4;
                    2: m_col = (m_col + 1) % 4;
                    3: m_row = (m_row + 63) % 64;
                    4: m_row = (m_row + 1) % 64;
                    default: ;
                endcase
            end
            c = (user_cursor > 4) ? 0 : int'(user_cursor);
            e = int'(user_edit);
            if (c == 0) begin m_cf = 0; cage = 0; end
            else if (c != cprev) begin m_cf = 1; cage = 0; m_cc = c; end
            else begin cage++; m_cf = (cage >= D) && ((cage - D) % P == 0); end
            if (e == 0) begin m_ef = 0; eage = 0; end
            else if (e != eprev) begin m_ef = 1; eage = 0; m_ec = e; end
            else begin eage++; m_ef = (eage >= D) && ((eage - D) % P == 0); end
            cprev = c;
            eprev = e;
        end
    end

    // monitor
    always @(negedge clk) begin
        logic [15:0] exp;
        if (run) begin
            chk("cursor_row", cursor_row, m_row);
            chk("cursor_col", cursor_col, m_col);
            chk("busy", busy, m_busy != 0);
            chk("mem_rd_en", mem_rd_en, m_busy == 3);
            chk("mem_wr_en", mem_wr_en, m_busy == 1);
            chk("edit_done", edit_done, m_busy == 1);
            if (mem_rd_en) chk("rd_addr", mem_addr, m_addr);
            if (mem_wr_en) begin
                wr_count++;
                if (exp_q.size() == 0) chk("unexpected_write", {mem_addr, mem_wdata}, 32'hDEAD);
                else begin
                    exp = exp_q.pop_front();
                    chk("write_addr_data", {mem_addr, mem_wdata}, exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_cursor(input logic [2:0] c);
        @(negedge clk) user_cursor = c;
        @(negedge clk) user_cursor = 3'd0;
        idle(4);
    endtask

    task automatic pulse_edit(input logic [1:0] e);
        @(negedge clk) user_edit = e;
        @(negedge clk) user_edit = 2'd0;
        idle(6);
    endtask

    initial begin
        int snap, hold;
        Reset = 1'b1;
        user_cursor = 3'd0;
        user_edit = 2'd0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'($urandom_range(0, 255));
        end
        ram[8'h0B] = 8'hFF;
        ram[8'h08] = 8'h3C;
        for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
        idle(3);
        Reset = 1'b0;
        run = 1;
        idle(2);
        chk("reset_row", cursor_row, 0);
        chk("reset_col", cursor_col, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);

        pulse_cursor(3'd2);
        chk("single_right_col", cursor_col, 1);
        chk("single_right_row", cursor_row, 0);
        pulse_cursor(3'd2);
        pulse_cursor(3'd2);
        pulse_cursor(3'd4);
        pulse_cursor(3'd4);
        chk("at_r2c3", {cursor_row, cursor_col}, 8'h0B);

        pulse_edit(2'd1);
        chk("inc_ff_wraps", ram[8'h0B], 8'h00);
        pulse_edit(2'd2);
        chk("dec_00_wraps", ram[8'h0B], 8'hFF);
        pulse_cursor(3'd2);
        pulse_edit(2'd3);
        chk("delete_3c", ram[8'h08], 8'h00);

        // hold up from row 0: moves at t0, +10, +14, +18
        @(negedge clk) Reset = 1'b1;
        @(negedge clk) Reset = 1'b0;
        @(negedge clk) user_cursor = 3'd3;
        idle(20);
        user_cursor = 3'd0;
        idle(3);
        chk("hold_up_row", cursor_row, 60);

        // simultaneous edit and cursor press: edit wins, cursor's first repeat moves it
        @(negedge clk) begin user_edit = 2'd2; user_cursor = 3'd4; end
        @(negedge clk) user_edit = 2'd0;
        idle(11);
        user_cursor = 3'd0;
        idle(4);
        chk("simul_row", cursor_row, 61);
        chk("simul_cell", ram[240], (ref_mem[240]));

        // reset while in WAIT aborts the write
        snap = wr_count;
        @(negedge clk) user_edit = 2'd1;
        @(negedge clk) user_edit = 2'd0;
        @(negedge clk);
        @(negedge clk) begin
            chk("in_wait_busy", busy, 1);
            Reset = 1'b1;
        end
        @(negedge clk) begin
            Reset = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_row", cursor_row, 0);
        end
        idle(5);
        chk("abort_no_write", wr_count, snap);

        // random phase
        for (int k = 0; k < 150; k++) begin
            user_cursor = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            user_edit = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            hold = $urandom_range(1, 25);
            if ($urandom_range(0, 40) == 0) Reset = 1'b1;
            @(negedge clk) Reset = 1'b0;
            idle(hold);
        end
        user_cursor = 3'd0;
        user_edit = 2'd0;
        idle(10);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
